cbus_rr_arbiter: RTL and testbench

CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

---
 rtl/cbus_rr_arbiter_pkg.sv | 38 +++
 rtl/cbus_rr_arbiter_if.sv | 58 +++++
 rtl/cbus_rr_arbiter_rr_select.sv | 44 ++++
 rtl/cbus_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter_pkg
// Shared cbus types plus the arbiter state encoding and a width helper.
// Everything cbus-facing in the arbiter, its interface and its bench imports
// this package, so the request/response layouts live in exactly one place.
//
// Contents:
//   cbus_req_t   - request beat  : valid, write, addr[15:0], wdata[31:0]
//   cbus_resp_t  - response beat : ready, last, data[31:0]
//   arb_state_t  - arbiter FSM states (ST_IDLE, ST_BUSY)
//   idx_width()  - index width for n requesters, never below 1 bit
// -----------------------------------------------------------------------------
package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // A single requester still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter_if
// Bundles every bus-side signal of the round-robin cbus arbiter.
//
// Signals:
//   ireqs[NUM_INPUTS]  - requests from each requester
//   iresps[NUM_INPUTS] - responses routed back to each requester
//   oreq               - request forwarded to the shared cbus
//   oresp              - response from the shared cbus
//   busy               - a transaction is currently granted
//   grant_idx          - current owner (meaningful only while busy)
//   timeout            - watchdog pulse (only with CBUS_ARB_WATCHDOG_EN)
//
// Modports:
//   master - the arbiter: drives oreq/iresps/status, samples ireqs/oresp
//   slave  - the surrounding system: drives ireqs/oresp, samples the rest
//
// Configuration macro: CBUS_ARB_WATCHDOG_EN adds the timeout signal.
// -----------------------------------------------------------------------------
interface cbus_rr_arbiter_if
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4
) ();

    localparam int IDX_W = idx_width(NUM_INPUTS);

    cbus_req_t  [NUM_INPUTS-1:0] ireqs;
    cbus_resp_t [NUM_INPUTS-1:0] iresps;
    cbus_req_t                   oreq;
    cbus_resp_t                  oresp;
    logic                        busy;
    logic [IDX_W-1:0]            grant_idx;
`ifdef CBUS_ARB_WATCHDOG_EN
    logic                        timeout;

    modport master (
        input  ireqs, oresp,
        output iresps, oreq, busy, grant_idx, timeout
    );

    modport slave (
        output ireqs, oresp,
        input  iresps, oreq, busy, grant_idx, timeout
    );
`else
    modport master (
        input  ireqs, oresp,
        output iresps, oreq, busy, grant_idx
    );

    modport slave (
        output ireqs, oresp,
        input  iresps, oreq, busy, grant_idx
    );
`endif

endinterface

// File: rtl/cbus_rr_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Purely combinational round-robin search: scans valid[] starting at ptr,
// wrapping modulo N, and reports the first set bit.
//
// Ports:
//   valid [N-1:0] - request vector
//   ptr   [W-1:0] - starting index (must be < N)
//   found         - at least one valid bit is set
//   idx   [W-1:0] - winning index (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_select #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan N positions from ptr; the earliest valid position in that order wins.
    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = W'(cand);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter
// Round-robin arbiter granting one of NUM_INPUTS cbus requesters access to a
// shared cbus. A grant is held for a whole burst and released only by
// oresp.last; one IDLE cycle always separates consecutive grants.
//
// Parameters:
//   NUM_INPUTS     - number of requesters (1..16)
//   TIMEOUT_CYCLES - watchdog limit in cycles (2..65535)
//
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high
//   bus   - cbus_rr_arbiter_if.master (ireqs, iresps, oreq, oresp, busy,
//           grant_idx and, with the watchdog, timeout)
//
// Configuration macro: CBUS_ARB_WATCHDOG_EN enables the burst watchdog, which
// counts BUSY cycles without oresp.last and pulses timeout once when the
// count first reaches TIMEOUT_CYCLES. The grant is never forcibly released.
// -----------------------------------------------------------------------------
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    cbus_rr_arbiter_if.master bus
);

    localparam int               IDX_W    = idx_width(NUM_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    arb_state_t                  state_r;
    arb_state_t                  state_s;
    logic [IDX_W-1:0]            grant_r;
    logic [IDX_W-1:0]            grant_s;
    logic [IDX_W-1:0]            rr_ptr_r;
    logic [IDX_W-1:0]            rr_ptr_s;
    logic [NUM_INPUTS-1:0]       valid_s;
    logic                        found_s;
    logic [IDX_W-1:0]            win_s;
    cbus_req_t                   oreq_s;
    cbus_resp_t [NUM_INPUTS-1:0] iresps_s;

    // Collect the valid bit of every requester into one vector.
    always_comb begin
        valid_s = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valid_s[i] = bus.ireqs[i].valid;
        end
    end

    rr_select #(
        .N (NUM_INPUTS),
        .W (IDX_W)
    ) u_rr_select (
        .valid (valid_s),
        .ptr   (rr_ptr_r),
        .found (found_s),
        .idx   (win_s)
    );

    // Next-state logic: grant on any request in IDLE, release only on last.
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        rr_ptr_s = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s = ST_BUSY;
                    grant_s = win_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.oresp.last) begin
                    state_s = ST_IDLE;
                    // Wrap explicitly so non-power-of-two counts stay in range.
                    if (grant_r == LAST_IDX) begin
                        rr_ptr_s = '0;
                    end else begin
                        rr_ptr_s = grant_r + IDX_W'(1);
                    end
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                grant_s  = '0;
                rr_ptr_s = '0;
            end
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_s;
            grant_r  <= grant_s;
            rr_ptr_r <= rr_ptr_s;
        end
    end

    // Route the owner's request out and the bus response back to the owner only.
    // Both follow state_r, so an asynchronous reset silences them immediately.
    always_comb begin
        oreq_s   = '0;
        iresps_s = '0;
        if (state_r == ST_BUSY) begin
            oreq_s            = bus.ireqs[grant_r];
            iresps_s[grant_r] = bus.oresp;
        end else begin
            oreq_s   = '0;
            iresps_s = '0;
        end
    end

    assign bus.oreq      = oreq_s;
    assign bus.iresps    = iresps_s;
    assign bus.busy      = (state_r == ST_BUSY);
    assign bus.grant_idx = grant_r;

`ifdef CBUS_ARB_WATCHDOG_EN
    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt_r;
    logic            timeout_r;

    // Watchdog: restart on BUSY entry, count stalled BUSY cycles, saturate.
    // timeout_r is set on the edge where the count moves to WD_MAX, so it is
    // high for exactly the one cycle in which the count first equals WD_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_r  <= '0;
            timeout_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && found_s) begin
                wd_cnt_r <= '0;
            end else if ((state_r == ST_BUSY) && !bus.oresp.last && (wd_cnt_r != WD_MAX)) begin
                wd_cnt_r <= wd_cnt_r + WD_W'(1);
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
            timeout_r <= (state_r == ST_BUSY) && !bus.oresp.last &&
                         (wd_cnt_r == (WD_MAX - WD_W'(1)));
        end
    end

    assign bus.timeout = timeout_r;
`endif

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cbus_rr_arbiter
// Directed self-checking bench for cbus_rr_arbiter (NUM_INPUTS=4,
// TIMEOUT_CYCLES=16). Expected values are hand-computed constants.
// The watchdog scenario is compiled only with CBUS_ARB_WATCHDOG_EN.
// -----------------------------------------------------------------------------
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    cbus_rr_arbiter_if #(.NUM_INPUTS(N)) bus ();

    cbus_rr_arbiter #(
        .NUM_INPUTS     (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cbus_req_t mk_req(input int i, input logic v);
        cbus_req_t r;
        r.valid = v;
        r.write = i[0];
        r.addr  = 16'h1000 + 16'(i);
        r.wdata = 32'hA000_0000 + 32'(i);
        return r;
    endfunction

    task automatic set_valids(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            bus.ireqs[i] = mk_req(i, v[i]);
        end
    endtask

    // Advance one clock and land 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cbus_resp_t exp_resp;
`ifdef CBUS_ARB_WATCHDOG_EN
        int pulses;
        int pulse_at;
`endif
        bus.ireqs = '0;
        bus.oresp = '0;
        reset     = 1'b1;
        step();
        step();

        // Reset state.
        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_grant", 64'(bus.grant_idx), 64'd0);
        check("rst_oreq",  64'(bus.oreq), 64'd0);
        for (int i = 0; i < N; i++) begin
            check("rst_iresp", 64'(bus.iresps[i]), 64'd0);
        end

        // Valids 1010 from ptr 0: requester 1 wins one edge later.
        reset = 1'b0;
        set_valids(4'b1010);
        #1;
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_oreq", 64'(bus.oreq), 64'd0);
        step();
        check("g1_busy",  64'(bus.busy), 64'd1);
        check("g1_grant", 64'(bus.grant_idx), 64'd1);
        check("g1_oreq",  64'(bus.oreq), 64'(mk_req(1, 1'b1)));
        exp_resp  = '{ready: 1'b1, last: 1'b0, data: 32'hDEAD_0001};
        bus.oresp = exp_resp;
        #1;
        check("g1_iresp1", 64'(bus.iresps[1]), 64'(exp_resp));
        check("g1_iresp0", 64'(bus.iresps[0]), 64'd0);
        check("g1_iresp3", 64'(bus.iresps[3]), 64'd0);
        bus.oresp.last = 1'b1;
        step();
        bus.oresp.last = 1'b0;
        #1;
        check("rel1_busy", 64'(bus.busy), 64'd0);
        check("rel1_oreq", 64'(bus.oreq), 64'd0);
        // ptr is now 2, so 3 is next.
        step();
        check("g3_busy",  64'(bus.busy), 64'd1);
        check("g3_grant", 64'(bus.grant_idx), 64'd3);
        bus.oresp.last = 1'b1;
        step();
        check("rel3_busy", 64'(bus.busy), 64'd0);

        // All valid, 1-beat bursts: 0,1,2,3,0 with an idle cycle between.
        set_valids(4'b1111);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_busy",  64'(bus.busy), 64'd1);
            check("rr_grant", 64'(bus.grant_idx), 64'(k % 4));
            step();
            check("rr_gap",   64'(bus.busy), 64'd0);
        end

        // ptr is 1; valids 1101 make requester 2 the owner of an 8-beat burst.
        bus.oresp.last = 1'b0;
        set_valids(4'b1101);
        step();
        check("b2_grant", 64'(bus.grant_idx), 64'd2);
        set_valids(4'b1111);
        for (int b = 1; b <= 8; b++) begin
            // Owner drops valid mid-burst; grant must still hold.
            if (b == 5) begin
                set_valids(4'b1011);
            end else begin
                b = b;
            end
            exp_resp  = '{ready: 1'b1, last: (b == 8), data: 32'(b)};
            bus.oresp = exp_resp;
            #1;
            check("b2_busy",   64'(bus.busy), 64'd1);
            check("b2_gidx",   64'(bus.grant_idx), 64'd2);
            check("b2_iresp2", 64'(bus.iresps[2]), 64'(exp_resp));
            check("b2_iresp0", 64'(bus.iresps[0]), 64'd0);
            check("b2_iresp1", 64'(bus.iresps[1]), 64'd0);
            check("b2_iresp3", 64'(bus.iresps[3]), 64'd0);
            step();
        end
        check("b2_release", 64'(bus.busy), 64'd0);
        bus.oresp = '0;
        set_valids(4'b1111);

        // ptr is 3: grant 3, then reset on beat 3 of its burst.
        step();
        check("r3_grant", 64'(bus.grant_idx), 64'd3);
        step();
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_busy",  64'(bus.busy), 64'd0);
        check("mid_rst_oreq",  64'(bus.oreq), 64'd0);
        check("mid_rst_grant", 64'(bus.grant_idx), 64'd0);
        check("mid_rst_iresp", 64'(bus.iresps[3]), 64'd0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_busy",  64'(bus.busy), 64'd1);
        check("post_rst_grant", 64'(bus.grant_idx), 64'd0);
        bus.oresp.last = 1'b1;
        step();
        bus.oresp.last = 1'b0;

        // 100 idle cycles with nothing valid; ptr must stay at 1.
        set_valids(4'b0000);
        for (int c = 0; c < 100; c++) begin
            step();
            if ((c % 20) == 0) begin
                check("quiet_busy", 64'(bus.busy), 64'd0);
                check("quiet_oreq", 64'(bus.oreq), 64'd0);
            end else begin
                c = c;
            end
        end
        set_valids(4'b1111);
        step();
        check("quiet_ptr_grant", 64'(bus.grant_idx), 64'd1);
        check("quiet_ptr_busy",  64'(bus.busy), 64'd1);
        bus.oresp.last = 1'b1;
        step();
        bus.oresp.last = 1'b0;

`ifdef CBUS_ARB_WATCHDOG_EN
        // last withheld: one pulse in BUSY cycle 16 (entry cycle = 0).
        set_valids(4'b0100);
        step();
        pulses   = 0;
        pulse_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (bus.timeout) begin
                pulses++;
                pulse_at = c;
            end else begin
                pulses = pulses;
            end
            step();
        end
        check("wd_pulses", 64'(pulses), 64'd1);
        check("wd_when",   64'(pulse_at), 64'd16);
        check("wd_busy",   64'(bus.busy), 64'd1);
        check("wd_grant",  64'(bus.grant_idx), 64'd2);
        bus.oresp.last = 1'b1;
        step();
        bus.oresp.last = 1'b0;
        check("wd_release", 64'(bus.busy), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
